// File: rtl/msxbus_pkg.sv
// Shared types, default timing constants and helpers for the MSX slot bus bridge.
package msxbus_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   localparam int unsigned DEF_NUM_SLOTS   = 2;
   localparam int unsigned DEF_CLK_HALF    = 8;
   localparam int unsigned DEF_SETUP_CYC   = 2;
   localparam int unsigned DEF_STROBE_CYC  = 4;
   localparam int unsigned DEF_HOLD_CYC    = 1;
   localparam int unsigned DEF_TIMEOUT     = 255;
   localparam int unsigned DEF_RST_STRETCH = 16;

   // Slot index width; a single slot still needs a one-bit index port.
   function automatic int unsigned slot_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/msxbus_clkdiv.sv
// Free-running msxclk divider and post-reset /RESET stretcher.
module msxbus_clkdiv
   import msxbus_pkg::*;
#(
   parameter int unsigned CLK_HALF    = DEF_CLK_HALF,
   parameter int unsigned RST_STRETCH = DEF_RST_STRETCH
) (
   input  logic clk,
   input  logic reset,
   output logic msxclk,
   output logic mreset,
   output logic rst_done_c
);

   localparam int unsigned DW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
   localparam int unsigned RW = (RST_STRETCH > 0) ? $clog2(RST_STRETCH + 1) : 1;

   logic [DW-1:0] div;
   logic [RW-1:0] rcnt;

   // Stretch is complete once this edge brings the post-reset count up to RST_STRETCH.
   always_comb begin
      rst_done_c = !reset && ((32'(rcnt) + 32'd1) >= RST_STRETCH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div    <= '0;
         msxclk <= 1'b0;
         rcnt   <= '0;
         mreset <= 1'b0;
      end else begin
         if (32'(div) == CLK_HALF - 1) begin
            div    <= '0;
            msxclk <= ~msxclk;
         end else begin
            div <= div + DW'(1);
         end
         if (32'(rcnt) < RST_STRETCH) begin
            rcnt <= rcnt + RW'(1);
         end
         mreset <= rst_done_c;
      end
   end

endmodule

// File: rtl/msxbus_bridge.sv
// Host register bus to MSX slot bus bridge: timed memory/IO cycles with /WAIT and timeout.
module msxbus_bridge
   import msxbus_pkg::*;
#(
   parameter  int unsigned NUM_SLOTS   = DEF_NUM_SLOTS,
   parameter  int unsigned CLK_HALF    = DEF_CLK_HALF,
   parameter  int unsigned SETUP_CYC   = DEF_SETUP_CYC,
   parameter  int unsigned STROBE_CYC  = DEF_STROBE_CYC,
   parameter  int unsigned HOLD_CYC    = DEF_HOLD_CYC,
   parameter  int unsigned TIMEOUT     = DEF_TIMEOUT,
   parameter  int unsigned RST_STRETCH = DEF_RST_STRETCH,
   localparam int unsigned SW          = slot_w(NUM_SLOTS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cs,
   input  logic                 a0,
   input  logic                 rw,
   input  logic                 mmeio,
   input  logic [SW-1:0]        sltsl,
   input  logic [15:0]          md_in,
   output logic [15:0]          md_out,
   output logic                 ready,
   output logic                 timeout,
   output logic [15:0]          maddr,
   input  logic [7:0]           mdata_in,
   output logic [7:0]           mdata_out,
   output logic                 mdata_oe,
   output logic [NUM_SLOTS-1:0] msltsl,
   output logic                 mrd,
   output logic                 mwr,
   output logic                 mmreq,
   output logic                 miorq,
   output logic                 mm1,
   output logic                 mreset,
   input  logic                 mwait,
   output logic                 mcs1,
   output logic                 mcs2,
   output logic                 mcs12,
   output logic                 mswsrc,
   output logic                 msxclk
);

   localparam int unsigned CW = $clog2(TIMEOUT + SETUP_CYC + HOLD_CYC + 1);

   state_t                 state, state_nxt;
   logic [CW-1:0]          cnt, cnt_nxt;
   logic                   rw_q, io_q;
   logic [SW-1:0]          slot_q;
   logic                   wait_m, wait_s;
   logic                   rst_done_c;
   logic                   accept, done, abort, active;
   logic                   rw_nxt, io_nxt;
   logic [SW-1:0]          slot_nxt;
   logic [15:0]            addr_nxt;
   logic [NUM_SLOTS-1:0]   sl_nxt;
   logic                   cs1_nxt, cs2_nxt;

   assign mm1    = 1'b1;
   assign mswsrc = 1'b1;

   msxbus_clkdiv #(
      .CLK_HALF    (CLK_HALF),
      .RST_STRETCH (RST_STRETCH)
   ) u_clkdiv (
      .clk        (clk),
      .reset      (reset),
      .msxclk     (msxclk),
      .mreset     (mreset),
      .rst_done_c (rst_done_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Sequencer plus next values of every bus output, so outputs line up with the state.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!cs && !a0 && ready) begin
               accept    = 1'b1;
               state_nxt = SETUP;
               cnt_nxt   = '0;
            end
         end
         SETUP: begin
            if (cnt == CW'(SETUP_CYC - 1)) begin
               state_nxt = STROBE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         STROBE: begin
            if (cnt == CW'(TIMEOUT - 1)) begin
               abort     = 1'b1;
               state_nxt = HOLD;
               cnt_nxt   = '0;
            end else if (cnt >= CW'(STROBE_CYC - 1) && wait_s) begin
               done      = 1'b1;
               state_nxt = HOLD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         HOLD: begin
            if (cnt == CW'(HOLD_CYC - 1)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      rw_nxt   = accept ? rw    : rw_q;
      io_nxt   = accept ? mmeio : io_q;
      slot_nxt = accept ? sltsl : slot_q;
      addr_nxt = accept ? md_in : maddr;
      active   = (state_nxt != IDLE);

      sl_nxt = '1;
      if (active && !io_nxt) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_nxt == SW'(i)) sl_nxt[i] = 1'b0;
         end
      end
      cs1_nxt = !((~&sl_nxt) && addr_nxt[15:14] == 2'b01);
      cs2_nxt = !((~&sl_nxt) && addr_nxt[15:14] == 2'b10);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_m    <= 1'b1;
         wait_s    <= 1'b1;
         rw_q      <= 1'b0;
         io_q      <= 1'b0;
         slot_q    <= '0;
         maddr     <= '0;
         mdata_out <= '0;
         mdata_oe  <= 1'b0;
         md_out    <= '0;
         timeout   <= 1'b0;
         ready     <= 1'b0;
         msltsl    <= '1;
         mrd       <= 1'b1;
         mwr       <= 1'b1;
         mmreq     <= 1'b1;
         miorq     <= 1'b1;
         mcs1      <= 1'b1;
         mcs2      <= 1'b1;
         mcs12     <= 1'b1;
      end else begin
         wait_m   <= mwait;
         wait_s   <= wait_m;
         rw_q     <= rw_nxt;
         io_q     <= io_nxt;
         slot_q   <= slot_nxt;
         maddr    <= addr_nxt;
         if (state == IDLE && !cs && a0) begin
            mdata_out <= md_in[7:0];
         end
         if (abort) begin
            md_out <= 16'h00FF;
         end else if (done && !rw_q) begin
            md_out <= {8'h00, mdata_in};
         end
         if (accept) begin
            timeout <= 1'b0;
         end else if (abort) begin
            timeout <= 1'b1;
         end
         ready    <= (state_nxt == IDLE) && rst_done_c;
         mdata_oe <= active && rw_nxt;
         msltsl   <= sl_nxt;
         mrd      <= !(state_nxt == STROBE && !rw_nxt);
         mwr      <= !(state_nxt == STROBE && rw_nxt);
         mmreq    <= !(active && !io_nxt);
         miorq    <= !(active && io_nxt);
         mcs1     <= cs1_nxt;
         mcs2     <= cs2_nxt;
         mcs12    <= cs1_nxt & cs2_nxt;
      end
   end

endmodule

// File: tb/tb_msxbus_bridge.sv
// Randomized self-checking bench for msxbus_bridge against a transaction-level timing model.
module tb_msxbus_bridge;

   localparam int unsigned NS = 2;
   localparam int unsigned SW = 1;
   localparam int SETUP = 2, STROBE = 4, HOLD = 1, TMO = 255, STRETCH = 16, HALF = 8;

   logic          clk = 1'b0;
   logic          reset, cs, a0, rw, mmeio, mwait;
   logic [SW-1:0] sltsl;
   logic [15:0]   md_in, md_out, maddr;
   logic [7:0]    mdata_in, mdata_out;
   logic          ready, timeout, mdata_oe, mrd, mwr, mmreq, miorq, mm1, mreset;
   logic          mcs1, mcs2, mcs12, mswsrc, msxclk;
   logic [NS-1:0] msltsl;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0]  wdata_m = 8'h00;
   logic [15:0] md_m    = 16'h0000;

   msxbus_bridge dut (
      .clk(clk), .reset(reset), .cs(cs), .a0(a0), .rw(rw), .mmeio(mmeio), .sltsl(sltsl),
      .md_in(md_in), .md_out(md_out), .ready(ready), .timeout(timeout), .maddr(maddr),
      .mdata_in(mdata_in), .mdata_out(mdata_out), .mdata_oe(mdata_oe), .msltsl(msltsl),
      .mrd(mrd), .mwr(mwr), .mmreq(mmreq), .miorq(miorq), .mm1(mm1), .mreset(mreset),
      .mwait(mwait), .mcs1(mcs1), .mcs2(mcs2), .mcs12(mcs12), .mswsrc(mswsrc), .msxclk(msxclk)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One host transaction; wlen = strobe cycles for which mwait is held low.
   task automatic run_txn(input bit wr, input bit io, input logic [SW-1:0] slot,
                          input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] rd,
                          input int wlen, input bit intrude);
      int cyc, strb, wrong, k;
      bit to, intruded;
      logic [NS-1:0] sl_exp, sl_obs;
      logic mmreq_o, miorq_o, oe_o, cs1_o, cs2_o, cs12_o, cs1_e, cs2_e;
      if (wr) begin
         cs = 1'b0; a0 = 1'b1; md_in = {8'hA5, wd};
         tick();
         wdata_m = wd;
      end
      check("ready_before_cmd", ready, 1);
      cs = 1'b0; a0 = 1'b0; md_in = addr; rw = wr; mmeio = io; sltsl = slot;
      mdata_in = rd; mwait = (wlen > 0) ? 1'b0 : 1'b1;
      tick();
      cs = 1'b1; md_in = 16'($urandom); rw = 1'($urandom); mmeio = 1'($urandom); sltsl = SW'($urandom);
      check("ready_drop", ready, 0);
      sl_obs = msltsl; mmreq_o = mmreq; miorq_o = miorq; oe_o = mdata_oe;
      cs1_o = mcs1; cs2_o = mcs2; cs12_o = mcs12;
      cyc = 0; strb = 0; wrong = 0; intruded = 1'b0;
      while (!ready && cyc < 400) begin
         if (wr ? !mwr : !mrd) strb++;
         if (wr ? !mrd : !mwr) wrong++;
         if (wlen > 0 && strb == wlen) mwait = 1'b1;
         if (intrude && strb == 2 && !intruded) begin
            cs = 1'b0; a0 = 1'($urandom); md_in = 16'hBEEF; intruded = 1'b1;
         end else begin
            cs = 1'b1;
         end
         tick();
         cyc++;
      end
      cs = 1'b1; mwait = 1'b1;
      // Expected strobe: minimum width, stretched by mwait low time plus the two-flop sync.
      k = (wlen == 0) ? STROBE : ((wlen + 2 > STROBE) ? wlen + 2 : STROBE);
      to = (k >= TMO);
      if (to) k = TMO;
      if (to) md_m = 16'h00FF;
      else if (!wr) md_m = {8'h00, rd};
      sl_exp = '1;
      if (!io) sl_exp[slot] = 1'b0;
      cs1_e = !(!io && addr[15:14] == 2'b01);
      cs2_e = !(!io && addr[15:14] == 2'b10);
      check("msltsl_active", sl_obs, sl_exp);
      check("mmreq_active", mmreq_o, io);
      check("miorq_active", miorq_o, !io);
      check("oe_active", oe_o, wr);
      check("mcs1", cs1_o, cs1_e);
      check("mcs2", cs2_o, cs2_e);
      check("mcs12", cs12_o, cs1_e & cs2_e);
      check("strobe_cycles", strb, k);
      check("wrong_strobe", wrong, 0);
      check("latency", cyc, SETUP + k + HOLD);
      check("md_out", md_out, md_m);
      check("timeout", timeout, to);
      check("maddr", maddr, addr);
      check("mdata_out", mdata_out, wdata_m);
      check("released", {mrd, mwr, mmreq, miorq, mdata_oe, msltsl}, {5'b11110, {NS{1'b1}}});
   endtask

   initial begin
      int n, t0, t1;
      logic prev;
      reset = 1'b1; cs = 1'b1; a0 = 1'b0; rw = 1'b0; mmeio = 1'b0; sltsl = '0;
      md_in = '0; mdata_in = '0; mwait = 1'b1;
      repeat (20) tick();
      check("rst_outputs", {ready, timeout, mreset, msxclk, mrd, mwr, mmreq, miorq, mm1, mdata_oe},
            10'b0000111110);
      check("rst_data", {md_out, maddr, mdata_out}, 40'h0);
      check("rst_msltsl", msltsl, {NS{1'b1}});
      check("mswsrc", mswsrc, 1);

      // Stretch period: a command issued now must be ignored.
      reset = 1'b0;
      n = 0;
      while (!mreset && n < 100) begin
         cs = (n == 5) ? 1'b0 : 1'b1; a0 = 1'b0; md_in = 16'h1234;
         tick();
         n++;
      end
      cs = 1'b1;
      check("mreset_stretch", n, STRETCH);
      check("ready_after_stretch", ready, 1);
      check("cmd_ignored_in_stretch", {maddr, mmreq}, {16'h0000, 1'b1});

      t0 = -1; t1 = -1; prev = msxclk;
      for (int i = 0; i < 100 && t1 < 0; i++) begin
         tick();
         if (!prev && msxclk) begin
            if (t0 < 0) t0 = i; else t1 = i;
         end
         prev = msxclk;
      end
      check("msxclk_period", t1 - t0, 2 * HALF);

      run_txn(1'b0, 1'b0, 1'b1, 16'h4123, 8'h00, 8'h5A, 0, 1'b0);
      run_txn(1'b1, 1'b1, 1'b0, 16'h0098, 8'hC3, 8'h00, 0, 1'b1);
      run_txn(1'b0, 1'b0, 1'b0, 16'h8010, 8'h00, 8'h3C, 10, 1'b0);
      run_txn(1'b0, 1'b0, 1'b1, 16'h4400, 8'h00, 8'h11, 1000, 1'b0);
      run_txn(1'b0, 1'b1, 1'b0, 16'h00A8, 8'h00, 8'h77, 0, 1'b1);

      for (int t = 0; t < 24; t++) begin
         run_txn(1'($urandom), 1'($urandom), SW'($urandom), 16'($urandom), 8'($urandom),
                 8'($urandom), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0,
                 1'($urandom));
      end

      // Reset in the middle of a strobe kills the cycle on the next edge.
      cs = 1'b0; a0 = 1'b0; md_in = 16'h8000; rw = 1'b0; mmeio = 1'b0; sltsl = '0; mwait = 1'b0;
      tick();
      cs = 1'b1;
      repeat (4) tick();
      check("mid_strobe_active", {mrd, mcs2, msltsl}, {1'b0, 1'b0, {NS-1{1'b1}}, 1'b0});
      reset = 1'b1;
      tick();
      check("mid_reset_ctrl", {mrd, mwr, mmreq, miorq, mdata_oe, ready, mreset}, 7'b1111000);
      check("mid_reset_slots", {msltsl, mcs1, mcs2, mcs12}, {{NS{1'b1}}, 3'b111});
      reset = 1'b0; mwait = 1'b1;
      n = 0;
      while (!ready && n < 100) begin
         tick();
         n++;
      end
      check("ready_after_mid_reset", n, STRETCH);
      wdata_m = 8'h00; md_m = 16'h0000;
      run_txn(1'b1, 1'b0, 1'b1, 16'h4FFE, 8'h96, 8'h00, 3, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
